// File: rtl/irq_vector_arbiter_pkg.sv
// irq_vector_arbiter_pkg: shared state encoding and defaults for the vectored-interrupt arbiter
package irq_vector_arbiter_pkg;
    typedef enum logic [1:0] {IDLE, GRANT, ACK, WAIT} state_t;
    localparam logic [15:0] SPURIOUS_VEC_DEFAULT = 16'o000000;
    function automatic int idx_w(input int n);
        return n > 1 ? $clog2(n) : 1;
    endfunction
endpackage

// File: rtl/irq_prio_enc.sv
// irq_prio_enc: lowest-index-wins priority encoder with found flag
module irq_prio_enc
    import irq_vector_arbiter_pkg::*;
#(
    parameter int N = 8,
    parameter int IW = idx_w(N)
) (
    input  logic [N-1:0]  req,
    output logic [IW-1:0] idx,
    output logic          found
);
    always_comb begin
        idx = '0;
        for (int i = N - 1; i >= 0; i--)
            if (req[i]) idx = IW'(i);
    end
    assign found = |req;
endmodule

// File: rtl/irq_vector_arbiter.sv
// irq_vector_arbiter: fixed-priority vectored interrupt arbiter answering the CPU istb/iack fetch
module irq_vector_arbiter
    import irq_vector_arbiter_pkg::*;
#(
    parameter int          N = 8,
    parameter logic [15:0] SPURIOUS_VEC = SPURIOUS_VEC_DEFAULT
) (
    input  logic            wb_clk_i,
    input  logic            wb_rst_i,
    input  logic [N-1:0]    irq_req,
    input  logic [16*N-1:0] irq_vec,
    output logic [N-1:0]    irq_ack,
    output logic            virq,
    output logic [15:0]     ivec,
    input  logic            istb,
    output logic            iack
);
    localparam int IW = idx_w(N);
    state_t state, state_nxt;
    logic [N-1:0] holdoff, eff_req;
    logic [IW-1:0] win_idx, sel;
    logic win_found, found;
    assign eff_req = irq_req & ~holdoff;
    irq_prio_enc #(.N(N), .IW(IW)) u_enc (
        .req(eff_req),
        .idx(win_idx),
        .found(win_found)
    );
    always_ff @(posedge wb_clk_i)
        state <= wb_rst_i ? IDLE : state_nxt;
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    state_nxt = istb ? GRANT : IDLE;
            GRANT:   state_nxt = ACK;
            ACK:     state_nxt = istb ? ACK : WAIT;
            default: state_nxt = IDLE;
        endcase
    end
    always_comb iack = state == ACK;
    // virq is suppressed from the cycle the fetch is accepted until after WAIT
    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            virq    <= 1'b0;
            ivec    <= '0;
            irq_ack <= '0;
            holdoff <= '0;
            sel     <= '0;
            found   <= 1'b0;
        end else begin
            virq    <= ((state == IDLE && !istb) || state == WAIT) && |eff_req;
            irq_ack <= '0;
            if (state == IDLE && istb) begin
                sel   <= win_idx;
                found <= win_found;
            end
            if (state == GRANT) begin
                ivec          <= found ? irq_vec[{sel, 4'b0000} +: 16] : SPURIOUS_VEC;
                irq_ack[sel]  <= found;
                holdoff[sel]  <= found;
            end
            if (state == WAIT) holdoff <= '0;
        end
    end
endmodule

// File: doc/irq_vector_arbiter.md
Name: irq_vector_arbiter

Overview:
- Vectored-interrupt arbiter that sits directly upstream of the processor board's interrupt inputs.
- Collects level requests from up to N peripheral controllers, raises virq, and answers the CPU's vector-fetch handshake (istb/iack) with the winning device's 16-bit vector.
- Returns a one-cycle acknowledge pulse to the granted device so it can drop its request.
- Replaces ad-hoc OR-ing of device requests on the top level.

Parameters:
- N, 8, number of request lines (1..16); index 0 has the highest priority.
- SPURIOUS_VEC, 16'o000000, vector returned if istb arrives with no live request.

Ports:
- wb_clk_i  in  1  system clock (same as processor clk_p).
- wb_rst_i  in  1  synchronous active-high reset.
- irq_req  in  N  level requests from devices, held until that device sees its irq_ack.
- irq_vec  in  16*N  flattened vectors; line k occupies bits [16k+15:16k].
- irq_ack  out  N  one-cycle grant pulse to the winning device.
- virq  out  1  to CPU: any unmasked request pending.
- ivec  out  16  vector bus to CPU.
- istb  in  1  CPU vector-fetch strobe.
- iack  out  1  vector valid / fetch acknowledge.

Behaviour:
- All state is clocked on posedge wb_clk_i. wb_rst_i is synchronous and active-high.
- Reset values: virq=0, ivec=0, iack=0, irq_ack=0, state=IDLE, holdoff mask=0.
- eff_req = irq_req & ~holdoff. virq is registered: virq <= |eff_req while state is IDLE or WAIT. This gives 1 cycle of latency from a request to virq.
- State machine:
  - IDLE: stays here while istb=0. When istb=1, latch the winner (lowest set index of eff_req) into sel and found=|eff_req, then go to GRANT.
  - GRANT (1 cycle):
    - ivec <= found ? irq_vec[sel] : SPURIOUS_VEC.
    - irq_ack[sel] <= found (one-hot pulse, exactly 1 cycle).
    - holdoff[sel] <= found.
    - Go to ACK.
  - ACK: iack=1 and ivec is stable. Stay while istb=1. When istb=0, drop iack next cycle and go to WAIT.
  - WAIT (1 cycle): clear holdoff, go to IDLE.
- iack asserts 2 cycles after istb is first seen high. iack is never asserted without a valid ivec on the same cycle.
- Winner is frozen at the IDLE->GRANT transition. Requests arriving or dropping later do not change ivec for the current fetch.
- holdoff masks the granted line until WAIT. This covers a device that takes one cycle to drop irq_req after irq_ack, so the same request is not re-granted.
- virq is forced to 0 during GRANT and ACK. It re-evaluates from WAIT onward, so a pending second request re-raises virq 1 cycle after WAIT.
- Simultaneous requests: fixed priority, lowest index wins. No fairness is provided.
- Request withdrawn before istb: the fetch completes with SPURIOUS_VEC and no irq_ack pulse. The CPU is never left hanging.
- Reset mid-handshake: outputs return to reset values on the next edge, iack drops, and no irq_ack is emitted.
- istb deasserted during GRANT: the ACK state still asserts iack for 1 cycle, then follows the normal release path.

Decomposition:
- Shared package: state encoding constants (IDLE, GRANT, ACK, WAIT) and the SPURIOUS_VEC default.
- One sub-module is natural: irq_prio_enc, a combinational N-input lowest-index priority encoder that outputs the index and a found flag.

Test Plan:
1. Single request: reset, then irq_req=8'b0000_0100 with vec2=16'o000060 → virq=1 one cycle later. Then istb=1 → irq_ack=8'b0000_0100 pulses 1 cycle, iack=1 with ivec=16'o000060 two cycles after istb. Device drops its request on ack → virq stays 0 after release.
2. Priority: requests on lines 1 and 5 (vectors 16'o000064 and 16'o000300). First fetch → 16'o000064 and ack on line 1. Virq re-asserts after WAIT. Second fetch → 16'o000300 and ack on line 5.
3. Slow device drop: line 0 drops irq_req one cycle after irq_ack → no second grant of line 0, and virq=0 after WAIT.
4. Spurious fetch: request on line 3 withdrawn the cycle before istb → ivec=16'o000000, iack=1, irq_ack all zero.
5. Late arrival: line 0 asserts during ACK of a line 4 fetch → ivec holds line 4's vector. Line 0 is granted on the next fetch.
6. Reset mid-fetch: wb_rst_i=1 while iack=1 → iack, virq, ivec and irq_ack are 0 on the next edge, and the state is IDLE.
